// File: rtl/f2c_chunk_fifo.sv
// Chunk-gated FPGA-to-CPU QW FIFO: data becomes visible to the DMA sender only
// once a full chunk of 2^CHUNK_NBITS QWs has been written. The head word is presented first-word-fall-through.
module f2c_chunk_fifo #(
  parameter int CHUNK_NBITS = 7,
  parameter int DEPTH_NBITS = 9
) (
  input  logic                               pcieClk_in,
  input  logic                               pcieRstN_in,
  input  logic [63:0]                        wrData_in,
  input  logic                               wrValid_in,
  output logic                               wrReady_out,
  output logic [63:0]                        f2cData_out,
  output logic                               f2cValid_out,
  input  logic                               f2cReady_in,
  input  logic                               f2cReset_in,
  output logic [DEPTH_NBITS:0]               level_out,
  output logic [DEPTH_NBITS-CHUNK_NBITS:0]   chunks_out,
  output logic                               underrun_out
);

  localparam int LVL_W = DEPTH_NBITS + 1;
  localparam int CNK_W = DEPTH_NBITS - CHUNK_NBITS + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = {1'b1, {DEPTH_NBITS{1'b0}}};

  if (DEPTH_NBITS <= CHUNK_NBITS) begin : g_bad_params
    $error("f2c_chunk_fifo: DEPTH_NBITS must exceed CHUNK_NBITS");
  end

  logic [DEPTH_NBITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CHUNK_NBITS-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [CNK_W-1:0]       chunks_q, chunks_d;
  logic                   underrun_q, underrun_d;
  logic [63:0]            mem_q [0:(1<<DEPTH_NBITS)-1];

  logic wr_acc, rd_acc, chunk_done, chunk_used;

  assign wrReady_out  = (level_q != FULL_LVL);
  assign f2cValid_out = (chunks_q != '0);
  assign f2cData_out  = mem_q[rd_ptr_q];
  assign level_out    = level_q;
  assign chunks_out   = chunks_q;
  assign underrun_out = underrun_q;

  always_comb begin
    wr_acc     = wrValid_in && wrReady_out;
    rd_acc     = f2cReady_in && f2cValid_out;
    chunk_done = wr_acc && (wr_off_q == '1);
    chunk_used = rd_acc && (rd_off_q == '1);

    wr_ptr_d   = wr_ptr_q + DEPTH_NBITS'(wr_acc);
    rd_ptr_d   = rd_ptr_q + DEPTH_NBITS'(rd_acc);
    wr_off_d   = wr_off_q + CHUNK_NBITS'(wr_acc);
    rd_off_d   = rd_off_q + CHUNK_NBITS'(rd_acc);

    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    chunks_d = chunks_q;
    case ({chunk_done, chunk_used})
      2'b10:   chunks_d = chunks_q + CNK_W'(1);
      2'b01:   chunks_d = chunks_q - CNK_W'(1);
      default: chunks_d = chunks_q;
    endcase

    underrun_d = underrun_q || (f2cReady_in && !f2cValid_out);

    // Flush discards everything, including accepts and underruns seen this cycle.
    if (f2cReset_in) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      wr_off_d   = '0;
      rd_off_d   = '0;
      level_d    = '0;
      chunks_d   = '0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_off_q   <= '0;
      rd_off_q   <= '0;
      level_q    <= '0;
      chunks_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_off_q   <= wr_off_d;
      rd_off_q   <= rd_off_d;
      level_q    <= level_d;
      chunks_q   <= chunks_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is not reset; the head is read asynchronously for zero-bubble FWFT.
  always_ff @(posedge pcieClk_in) begin
    if (wr_acc && !f2cReset_in) begin
      mem_q[wr_ptr_q] <= wrData_in;
    end
  end

endmodule

// File: tb/tb_f2c_chunk_fifo.sv
// Scoreboard bench for f2c_chunk_fifo with 4-QW chunks and an 8-QW FIFO.
module tb_f2c_chunk_fifo;

  localparam int CN = 2;
  localparam int DN = 3;
  localparam int CHUNK = 1 << CN;

  logic              clk;
  logic              rst_n;
  logic [63:0]       wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [63:0]       f2c_data;
  logic              f2c_valid;
  logic              f2c_ready;
  logic              f2c_reset;
  logic [DN:0]       level;
  logic [DN-CN:0]    chunks;
  logic              underrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];
  int wr_tot = 0;
  int rd_tot = 0;

  f2c_chunk_fifo #(.CHUNK_NBITS(CN), .DEPTH_NBITS(DN)) dut (
    .pcieClk_in   (clk),
    .pcieRstN_in  (rst_n),
    .wrData_in    (wr_data),
    .wrValid_in   (wr_valid),
    .wrReady_out  (wr_ready),
    .f2cData_out  (f2c_data),
    .f2cValid_out (f2c_valid),
    .f2cReady_in  (f2c_ready),
    .f2cReset_in  (f2c_reset),
    .level_out    (level),
    .chunks_out   (chunks),
    .underrun_out (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive, let comb settle, score accepts, clock, return 1ns after edge.
  task automatic step(input logic wv, input logic [63:0] d, input logic rr, input logic fl);
    logic [63:0] exp_d;
    wr_valid  = wv;
    wr_data   = d;
    f2c_ready = rr;
    f2c_reset = fl;
    #2;
    if (fl) begin
      sb_q.delete();
      wr_tot = 0;
      rd_tot = 0;
    end else begin
      if (wv && wr_ready) begin
        sb_q.push_back(d);
        wr_tot++;
      end
      if (rr && f2c_valid) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL read_data: read accepted with got valid=1, expected empty scoreboard");
        end else begin
          exp_d = sb_q.pop_front();
          if (f2c_data !== exp_d) begin
            n_fail++;
            $display("FAIL read_data: got %0d expected %0d", f2c_data, exp_d);
          end
        end
        rd_tot++;
      end
    end
    @(posedge clk);
    #1;
    wr_valid  = 1'b0;
    f2c_ready = 1'b0;
    f2c_reset = 1'b0;
  endtask

  task automatic drain_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (f2c_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_valid_hold: read %0d got valid=%b expected 1", tag, i, f2c_valid);
      end
      step(1'b0, 64'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (level !== 4'd0 || chunks !== 2'd0 || f2c_valid !== 1'b0 ||
        wr_ready !== 1'b1 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got level=%0d chunks=%0d valid=%b ready=%b underrun=%b expected 0 0 0 1 0",
               level, chunks, f2c_valid, wr_ready, underrun);
    end
  endtask

  task automatic test_chunk_visible();
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 64'(i), 1'b0, 1'b0);
      n_tests++;
      if (f2c_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL partial_hidden: after QW %0d got valid=%b expected 0", i, f2c_valid);
      end
    end
    n_tests++;
    if (level !== 4'd3) begin
      n_fail++;
      $display("FAIL partial_level: got %0d expected 3", level);
    end
    step(1'b1, 64'd4, 1'b0, 1'b0);
    n_tests++;
    if (chunks !== 2'd1 || f2c_valid !== 1'b1 || f2c_data !== 64'd1) begin
      n_fail++;
      $display("FAIL chunk_complete: got chunks=%0d valid=%b data=%0d expected 1 1 1",
               chunks, f2c_valid, f2c_data);
    end
  endtask

  task automatic test_stream();
    for (int i = 5; i <= 8; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
    n_tests++;
    if (chunks !== 2'd2 || level !== 4'd8) begin
      n_fail++;
      $display("FAIL two_chunks: got chunks=%0d level=%0d expected 2 8", chunks, level);
    end
    drain_n(8, "stream");
    n_tests++;
    if (f2c_valid !== 1'b0 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL stream_end: got valid=%b level=%0d expected 0 0", f2c_valid, level);
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 11; i <= 18; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
    n_tests++;
    if (wr_ready !== 1'b0 || level !== 4'd8 || chunks !== 2'd2) begin
      n_fail++;
      $display("FAIL full: got ready=%b level=%0d chunks=%0d expected 0 8 2", wr_ready, level, chunks);
    end
    step(1'b1, 64'd19, 1'b1, 1'b0);
    n_tests++;
    if (wr_ready !== 1'b1 || level !== 4'd7) begin
      n_fail++;
      $display("FAIL full_read: got ready=%b level=%0d expected 1 7", wr_ready, level);
    end
    step(1'b1, 64'd19, 1'b0, 1'b0);
    n_tests++;
    if (wr_ready !== 1'b0 || level !== 4'd8) begin
      n_fail++;
      $display("FAIL refill: got ready=%b level=%0d expected 0 8", wr_ready, level);
    end
    drain_n(7, "wrap");
    n_tests++;
    if (f2c_valid !== 1'b0 || level !== 4'd1 || chunks !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_partial: got valid=%b level=%0d chunks=%0d expected 0 1 0",
               f2c_valid, level, chunks);
    end
    for (int i = 20; i <= 22; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
    drain_n(4, "wrap2");
    n_tests++;
    if (level !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_empty: got level=%0d expected 0", level);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 7; i++) step(1'b1, 64'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1, 1'b0);
    step(1'b1, 64'd108, 1'b1, 1'b0);
    n_tests++;
    if (chunks !== 2'd1 || level !== 4'd4) begin
      n_fail++;
      $display("FAIL simul_complete_consume: got chunks=%0d level=%0d expected 1 4", chunks, level);
    end
    drain_n(4, "simul");
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 6; i++) step(1'b1, 64'(200 + i), 1'b0, 1'b0);
    step(1'b1, 64'd299, 1'b0, 1'b1);
    n_tests++;
    if (level !== 4'd0 || chunks !== 2'd0 || f2c_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: got level=%0d chunks=%0d valid=%b expected 0 0 0", level, chunks, f2c_valid);
    end
    for (int i = 1; i <= 3; i++) step(1'b1, 64'(300 + i), 1'b0, 1'b0);
    n_tests++;
    if (f2c_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_fresh_partial: got valid=%b expected 0", f2c_valid);
    end
    step(1'b1, 64'd304, 1'b0, 1'b0);
    n_tests++;
    if (chunks !== 2'd1 || f2c_data !== 64'd301) begin
      n_fail++;
      $display("FAIL flush_fresh_chunk: got chunks=%0d data=%0d expected 1 301", chunks, f2c_data);
    end
    drain_n(4, "flush");
  endtask

  task automatic test_underrun();
    step(1'b0, 64'd0, 1'b1, 1'b0);
    n_tests++;
    if (underrun !== 1'b1 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL underrun_set: got underrun=%b level=%0d expected 1 0", underrun, level);
    end
    step(1'b0, 64'd0, 1'b0, 1'b0);
    n_tests++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_sticky: got %b expected 1", underrun);
    end
    step(1'b0, 64'd0, 1'b0, 1'b1);
    n_tests++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_flush: got %b expected 0", underrun);
    end
    step(1'b0, 64'd0, 1'b1, 1'b0);
    step(1'b1, 64'd401, 1'b0, 1'b0);
    step(1'b1, 64'd402, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (level !== 4'd0 || chunks !== 2'd0 || underrun !== 1'b0 ||
        wr_ready !== 1'b1 || f2c_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got level=%0d chunks=%0d underrun=%b ready=%b valid=%b expected 0 0 0 1 0",
               level, chunks, underrun, wr_ready, f2c_valid);
    end
    sb_q.delete();
    wr_tot = 0;
    rd_tot = 0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) step(1'b1, 64'(500 + i), 1'b0, 1'b0);
    n_tests++;
    if (f2c_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_partial: got valid=%b expected 0", f2c_valid);
    end
    step(1'b1, 64'd504, 1'b0, 1'b0);
    n_tests++;
    if (f2c_valid !== 1'b1 || f2c_data !== 64'd501) begin
      n_fail++;
      $display("FAIL post_reset_chunk: got valid=%b data=%0d expected 1 501", f2c_valid, f2c_data);
    end
    drain_n(4, "post_reset");
  endtask

  task automatic test_random();
    logic wv, rr;
    int exp_chunks;
    for (int i = 0; i < 300; i++) begin
      wv = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < 45);
      step(wv, {32'hCAFE_0000, 32'($urandom)}, rr, ($urandom_range(0, 199) == 0));
      exp_chunks = (wr_tot / CHUNK) - (rd_tot / CHUNK);
      n_tests++;
      if (level !== 4'(sb_q.size()) || chunks !== 2'(exp_chunks)) begin
        n_fail++;
        $display("FAIL random_counts: cycle %0d got level=%0d chunks=%0d expected %0d %0d",
                 i, level, chunks, sb_q.size(), exp_chunks);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    f2c_ready = 1'b0;
    f2c_reset = 1'b0;
    #1;
    test_reset();
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_chunk_visible();
    test_stream();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_underrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/f2c_chunk_fifo.md
F2C_CHUNK_FIFO -- requirements
Module: f2c_chunk_fifo

Interface
REQ-001 SHALL have parameter CHUNK_NBITS, default 7, log2 of QWs per F2C chunk (128 QW = 1024 bytes).
REQ-002 SHALL have parameter DEPTH_NBITS, default 9, log2 of FIFO depth in QWs (512); elaboration SHALL fail unless DEPTH_NBITS > CHUNK_NBITS.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of pcieClk_in.
REQ-004 pcieClk_in  input  1  125MHz PCIe core clock.
REQ-005 pcieRstN_in  input  1  asynchronous active-low reset.
REQ-006 wrData_in  input  64  producer QW.
REQ-007 wrValid_in  input  1  producer QW valid.
REQ-008 wrReady_out  output  1  FIFO can accept a QW this cycle.
REQ-009 f2cData_out  output  64  QW at FIFO head, for the DMA sender.
REQ-010 f2cValid_out  output  1  at least one complete chunk is buffered.
REQ-011 f2cReady_in  input  1  DMA sender consumes head QW this cycle.
REQ-012 f2cReset_in  input  1  synchronous flush request from the DMA sender.
REQ-013 level_out  output  DEPTH_NBITS+1  QWs currently stored.
REQ-014 chunks_out  output  DEPTH_NBITS-CHUNK_NBITS+1  complete chunks currently stored.
REQ-015 underrun_out  output  1  sticky: f2cReady_in seen with f2cValid_out low.

Function
REQ-016 Write accepted iff wrValid_in && wrReady_out; wrReady_out SHALL equal (level_out != 2^DEPTH_NBITS), combinational from registered level.
REQ-017 Read accepted iff f2cReady_in && f2cValid_out; f2cReady_in with f2cValid_out low SHALL NOT move any pointer or count.
REQ-018 f2cValid_out SHALL equal (chunks_out != 0); partially written chunks SHALL never be visible.
REQ-019 Once f2cValid_out rises it SHALL stay high for at least 2^CHUNK_NBITS consecutive accepted reads (sender reads a chunk back-to-back without rechecking valid).
REQ-020 f2cData_out SHALL be first-word-fall-through: head QW presented in the same cycle f2cValid_out is high, next QW presented the cycle after each accepted read, zero bubble.
REQ-021 Write pointer, read pointer: DEPTH_NBITS bits, increment by one per accepted op, wrap modulo 2^DEPTH_NBITS.
REQ-022 Write offset-in-chunk (CHUNK_NBITS bits) SHALL wrap to 0 on the accept of the last QW of a chunk; that cycle is a chunk-complete event.
REQ-023 Read offset-in-chunk SHALL likewise wrap on the accept of the last QW of a chunk; that cycle is a chunk-consumed event.
REQ-024 chunks_out SHALL be +1 on complete only, -1 on consumed only, unchanged when both occur in one cycle.
REQ-025 level_out SHALL be +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-026 Latency: chunk-complete accepted in cycle N -> chunks_out incremented and f2cValid_out high in cycle N+1.
REQ-027 Full: write at level 2^DEPTH_NBITS is impossible (wrReady_out low); a simultaneous read that frees space SHALL NOT raise wrReady_out until the next cycle.
REQ-028 f2cReset_in high in cycle N SHALL, in cycle N+1, give both pointers, both offsets, level_out, chunks_out and underrun_out = 0; partial and complete chunks are discarded.
REQ-029 f2cReset_in SHALL take priority over any write or read in the same cycle; such accepts are discarded.
REQ-030 underrun_out SHALL set one cycle after an illegal f2cReady_in and stay set until reset or flush.
REQ-031 Storage SHALL be 2^DEPTH_NBITS x 64; inferred RAM plus a lookahead register is permitted if REQ-020 port timing holds.

Reset
REQ-032 While pcieRstN_in low, immediately and asynchronously: pointers, offsets, level_out, chunks_out, underrun_out = 0; f2cValid_out = 0; wrReady_out = 1.
REQ-033 f2cData_out SHALL be don't-care while f2cValid_out is low; RAM contents are not reset.
REQ-034 Reset assertion mid-chunk SHALL discard all stored data; first write after release starts chunk offset 0.

Verification (CHUNK_NBITS=2, DEPTH_NBITS=3)
REQ-035 Write QWs 1..3 -> f2cValid_out stays 0, level_out=3; write QW 4 in cycle N -> cycle N+1 chunks_out=1, f2cValid_out=1, f2cData_out=1.
REQ-036 Two chunks (1..8) written, f2cReady_in held high -> data 1..8 on consecutive cycles, f2cValid_out drops the cycle after QW 8, level_out=0.
REQ-037 Fill 8 QWs -> wrReady_out=0; read one with wrValid_in high -> wrReady_out returns 1 next cycle, QW 9 accepted after, pointer wrap data order correct.
REQ-038 Write of last QW of chunk 2 in the same cycle as read of last QW of chunk 1 -> chunks_out stays 1, level_out unchanged.
REQ-039 Six QWs stored, pulse f2cReset_in with a simultaneous write -> next cycle level_out=0, chunks_out=0, f2cValid_out=0; next 4 writes form a fresh chunk.
REQ-040 f2cReady_in high on empty FIFO -> underrun_out=1 next cycle, level unchanged; async reset mid-chunk -> all counts 0 without a clock edge.
